// File: rtl/sid_i2s_out_if.sv
// rtl/sid_i2s_out_if.sv - sample input and I2S/status outputs of sid_i2s_out
interface sid_i2s_out_if;
  logic        CLKen;
  logic [15:0] SAMPLE;
  logic        I2S_BCLK;
  logic        I2S_LRCLK;
  logic        I2S_DATA;
  logic        SAMPLE_STB;
  logic        OVERRUN;
  logic        UNDERRUN;

  modport master (
    output CLKen, SAMPLE,
    input  I2S_BCLK, I2S_LRCLK, I2S_DATA, SAMPLE_STB, OVERRUN, UNDERRUN
  );

  modport slave (
    input  CLKen, SAMPLE,
    output I2S_BCLK, I2S_LRCLK, I2S_DATA, SAMPLE_STB, OVERRUN, UNDERRUN
  );
endinterface

// File: rtl/sid_i2s_out.sv
// rtl/sid_i2s_out.sv - box-car decimator with single-entry hold feeding a free-running I2S transmitter
module sid_i2s_out #(
  parameter int DECIM_LOG2 = 5,
  parameter int BCLK_DIV   = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  sid_i2s_out_if.slave bus
);
  localparam int ACC_W = 16 + DECIM_LOG2;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic signed [ACC_W-1:0] acc;
  logic [DECIM_LOG2-1:0]   tick;
  logic [15:0]             hold;
  logic [15:0]             word;
  logic                    valid;
  logic [DIV_W-1:0]        div;
  logic [5:0]              bit_cnt;
  logic                    bclk;
  logic                    lrclk;
  logic                    data;
  logic                    stb;
  logic                    ovr;
  logic                    udr;

  logic signed [ACC_W-1:0] acc_sum;
  logic [15:0]             avg;
  logic                    term;
  logic                    div_wrap;
  logic                    fall;
  logic                    load;
  logic [5:0]              bit_nxt;
  logic [4:0]              slot_pos;
  logic                    ser_bit;

  always_comb begin
    acc_sum  = acc + {{DECIM_LOG2{bus.SAMPLE[15]}}, bus.SAMPLE};
    avg      = 16'(acc_sum >>> DECIM_LOG2);
    term     = bus.CLKen && (tick == '1);
    div_wrap = (div == DIV_LAST);
    fall     = div_wrap && bclk;
    load     = fall && (bit_cnt == 6'd63);
    bit_nxt  = bit_cnt + 6'd1;
    slot_pos = bit_nxt[4:0];
    // Slot positions 1..16 carry the word MSB first; position 0 is the I2S one-bit delay.
    ser_bit  = 1'b0;
    if ((slot_pos != 5'd0) && (slot_pos <= 5'd16)) begin
      ser_bit = word[4'(5'd16 - slot_pos)];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      acc     <= '0;
      tick    <= '0;
      hold    <= '0;
      word    <= '0;
      valid   <= 1'b0;
      div     <= '0;
      bit_cnt <= 6'd63;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      data    <= 1'b0;
      stb     <= 1'b0;
      ovr     <= 1'b0;
      udr     <= 1'b0;
    end else begin
      stb <= 1'b0;
      ovr <= 1'b0;
      udr <= 1'b0;

      if (bus.CLKen) begin
        tick <= tick + 1'b1;
        if (term) begin
          acc  <= '0;
          hold <= avg;
          stb  <= 1'b1;
          ovr  <= valid && !load;
        end else begin
          acc <= acc_sum;
        end
      end

      // A terminal tick on the load cycle refills the hold, so valid stays set.
      if (term) begin
        valid <= 1'b1;
      end else if (load) begin
        valid <= 1'b0;
      end

      div <= div_wrap ? '0 : div + 1'b1;
      if (div_wrap) begin
        bclk <= ~bclk;
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= bit_nxt[5];
        data    <= ser_bit;
        if (load) begin
          if (valid) begin
            word <= hold;
          end else begin
            udr <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.I2S_BCLK   = bclk;
  assign bus.I2S_LRCLK  = lrclk;
  assign bus.I2S_DATA   = data;
  assign bus.SAMPLE_STB = stb;
  assign bus.OVERRUN    = ovr;
  assign bus.UNDERRUN   = udr;
endmodule

// File: tb/tb_sid_i2s_out.sv
// tb/tb_sid_i2s_out.sv - directed bench for sid_i2s_out against a time-based behavioural model
`timescale 1ns/1ps
module tb_sid_i2s_out;
  localparam int BD    = 4;
  localparam int DL    = 5;
  localparam int NDEC  = 1 << DL;
  localparam int FRAME = 128 * BD;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  sid_i2s_out_if bus_if ();

  sid_i2s_out #(.DECIM_LOG2(DL), .BCLK_DIV(BD)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus_if)
  );

  always #5 CLK = ~CLK;

  // Model state: m_n counts CLK edges since reset release; everything else follows from it.
  int          m_n     = 0;
  int          m_sum   = 0;
  int          m_cnt   = 0;
  logic [15:0] m_hold  = '0;
  logic [15:0] m_word  = '0;
  logic        m_valid = 1'b0;
  logic        m_bclk  = 1'b0;
  logic        m_lr    = 1'b0;
  logic        m_data  = 1'b0;
  logic        m_stb   = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_udr   = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int n_stb = 0, n_ovr = 0, n_udr = 0;
  int lit_done = 0;

  int          lit_seq = 0;
  string       lit_name;
  logic [15:0] lit_act;
  logic [15:0] lit_exp;

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic int cur_bit();
    return (m_n >= 2*BD) ? ((m_n / (2*BD)) - 1) % 64 : 63;
  endfunction

  function automatic int cur_phase();
    return (m_n >= 2*BD) ? (m_n - 2*BD) % FRAME : -1;
  endfunction

  task automatic model_reset();
    m_n = 0; m_sum = 0; m_cnt = 0;
    m_hold = '0; m_word = '0; m_valid = 1'b0;
    m_bclk = 1'b0; m_lr = 1'b0; m_data = 1'b0;
    m_stb = 1'b0; m_ovr = 1'b0; m_udr = 1'b0;
  endtask

  task automatic model_step();
    int   b;
    int   p;
    logic was_valid;
    logic frame_start;
    m_n       = m_n + 1;
    was_valid = m_valid;
    m_stb = 1'b0; m_ovr = 1'b0; m_udr = 1'b0;
    frame_start = (m_n >= 2*BD) && (m_n % (2*BD) == 0) && (cur_bit() == 0);
    if (frame_start) begin
      if (was_valid) begin
        m_word  = m_hold;
        m_valid = 1'b0;
      end else begin
        m_udr = 1'b1;
      end
    end
    if (bus_if.CLKen) begin
      m_sum = m_sum + int'($signed(bus_if.SAMPLE));
      m_cnt = m_cnt + 1;
      if (m_cnt == NDEC) begin
        m_hold  = 16'(floor_div(m_sum, NDEC));
        m_sum   = 0;
        m_cnt   = 0;
        m_valid = 1'b1;
        m_stb   = 1'b1;
        m_ovr   = was_valid && !frame_start;
      end
    end
    m_bclk = ((m_n / BD) % 2) == 1;
    if (m_n >= 2*BD) begin
      b      = cur_bit();
      p      = b % 32;
      m_lr   = (b >= 32);
      m_data = (p >= 1 && p <= 16) ? m_word[16-p] : 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) model_reset();
      else model_step();
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s @%0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      check("bclk",   16'(bus_if.I2S_BCLK),   16'(m_bclk));
      check("lrclk",  16'(bus_if.I2S_LRCLK),  16'(m_lr));
      check("data",   16'(bus_if.I2S_DATA),   16'(m_data));
      check("stb",    16'(bus_if.SAMPLE_STB), 16'(m_stb));
      check("ovr",    16'(bus_if.OVERRUN),    16'(m_ovr));
      check("udr",    16'(bus_if.UNDERRUN),   16'(m_udr));
      if (bus_if.SAMPLE_STB === 1'b1) n_stb = n_stb + 1;
      if (bus_if.OVERRUN === 1'b1)    n_ovr = n_ovr + 1;
      if (bus_if.UNDERRUN === 1'b1)   n_udr = n_udr + 1;
      if (lit_seq != lit_done) begin
        check(lit_name, lit_act, lit_exp);
        lit_done = lit_seq;
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
    lit_name = nm;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq  = lit_seq + 1;
    @(negedge CLK);
    #1;
  endtask

  task automatic cyc(input logic en, input logic [15:0] s);
    bus_if.CLKen  = en;
    bus_if.SAMPLE = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic feed(input int n, input int period, input logic [15:0] s0, input logic [15:0] s1);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, (i % 2 == 0) ? s0 : s1);
      for (int j = 1; j < period; j++) cyc(1'b0, 16'h0);
    end
  endtask

  task automatic wait_phase(input int ph, input string nm);
    int guard;
    guard = 0;
    do begin
      cyc(1'b0, 16'h0);
      guard = guard + 1;
    end while (cur_phase() != ph && guard < 4*FRAME);
    if (cur_phase() != ph) lit(nm, 16'h0, 16'h1);
  endtask

  task automatic startup_check(input string tag);
    int rise_at;
    int udr_at;
    rise_at = -1;
    udr_at  = -1;
    for (int i = 1; i <= 4*BD + 8; i++) begin
      cyc(1'b0, 16'h0);
      if (rise_at < 0 && bus_if.I2S_BCLK === 1'b1) rise_at = i;
      if (udr_at < 0 && bus_if.UNDERRUN === 1'b1) udr_at = i;
    end
    lit({tag, "_bclk_rise"}, 16'(rise_at), 16'(BD));
    lit({tag, "_underrun_at"}, 16'(udr_at), 16'(2*BD));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog @%0t: bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int o0;
    int u0;
    int guard;
    bus_if.CLKen  = 1'b0;
    bus_if.SAMPLE = 16'h0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    startup_check("start");

    feed(NDEC, 16, 16'h1234, 16'h1234);
    lit("hold_const", m_hold, 16'h1234);
    feed(NDEC, 16, 16'h1234, 16'h1234);
    lit("word_const", m_word, 16'h1234);

    feed(NDEC, 16, 16'd100, 16'hFF9B);
    lit("hold_floor", m_hold, 16'hFFFF);
    feed(NDEC, 16, 16'h8000, 16'h8000);
    lit("hold_min", m_hold, 16'h8000);
    feed(NDEC, 16, 16'h7FFF, 16'h7FFF);
    lit("hold_max", m_hold, 16'h7FFF);

    s0 = n_stb;
    o0 = n_ovr;
    for (int i = 0; i < 20; i++) feed(NDEC, 1, 16'(i*1500 - 9000), 16'(i*37));
    cyc(1'b0, 16'h0);
    lit("overrun_stb_count", 16'(n_stb - s0), 16'd20);
    lit("overrun_seen", 16'((n_ovr - o0) >= 17), 16'd1);

    wait_phase(0, "underrun_sync");
    feed(NDEC, 1, 16'h0321, 16'h0321);
    u0 = n_udr;
    s0 = n_stb;
    repeat (3*FRAME) cyc(1'b0, 16'h0);
    lit("underrun_count", 16'(n_udr - u0), 16'd2);
    lit("underrun_word", m_word, 16'h0321);

    wait_phase(0, "coinc_sync");
    o0 = n_ovr;
    feed(NDEC, 1, 16'h0AAA, 16'h0AAA);
    feed(NDEC - 1, 1, 16'h0555, 16'h0555);
    wait_phase(FRAME - 1, "coinc_align");
    cyc(1'b1, 16'h0555);
    cyc(1'b0, 16'h0);
    lit("coinc_word_old", m_word, 16'h0AAA);
    lit("coinc_hold_new", m_hold, 16'h0555);
    lit("coinc_valid", 16'(m_valid), 16'd1);
    lit("coinc_no_overrun", 16'(n_ovr - o0), 16'd0);
    repeat (FRAME) cyc(1'b0, 16'h0);
    lit("coinc_next_word", m_word, 16'h0555);

    guard = 0;
    do begin
      cyc(1'b0, 16'h0);
      guard = guard + 1;
    end while (cur_bit() != 40 && guard < 2*FRAME);
    if (cur_bit() != 40) lit("rst_mid_sync", 16'h0, 16'h1);
    lit("lrclk_before_reset", 16'(bus_if.I2S_LRCLK), 16'd1);
    RSTn = 1'b0;
    #1;
    lit("lrclk_in_reset", 16'(bus_if.I2S_LRCLK), 16'd0);
    repeat (3) cyc(1'b0, 16'h0);
    RSTn = 1'b1;
    startup_check("rst_mid");
    repeat (FRAME) cyc(1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
